rf68000_ring_nic_q: RTL and testbench

RF68000_RING_NIC_Q -- requirements
Module: rf68000_ring_nic_q

---
 rtl/rf68000_ring_nic_q.sv | 353 +++++++++++++++++++++++++++++++++++
 tb/tb_rf68000_ring_nic_q.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf68000_ring_nic_q.sv
`default_nettype none
// ============================================================================
//  Module   : rf68000_ring_nic_q
//  Purpose  : Ring network interface. A slave bus port turns local accesses
//             into request packets, and a master bus port executes requests
//             addressed to this node. Two slotted rings carry the packets:
//             one for requests and one for responses.
//  Revision : 1.0  initial release
// ============================================================================
module rf68000_ring_nic_q #(
  parameter int ID_W      = 6,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TXQ_DEPTH = 4,
  parameter int MAX_AGE   = 63,
  parameter int TIMEOUT   = 1023,
  parameter int SERVER_ID = 62,
  localparam int PW       = 2*ID_W + 6 + 3 + DW/8 + AW + DW
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [ID_W-1:0]    id_i,
  // slave port (local bus master accesses the ring)
  input  logic               s_cyc_i,
  input  logic               s_stb_i,
  input  logic               s_we_i,
  input  logic [DW/8-1:0]    s_sel_i,
  input  logic [AW-1:0]      s_adr_i,
  input  logic [DW-1:0]      s_dat_i,
  output logic               s_ack_o,
  output logic               s_rty_o,
  output logic [DW-1:0]      s_dat_o,
  // master port (ring requests executed on the local bus)
  output logic               m_cyc_o,
  output logic               m_stb_o,
  output logic               m_we_o,
  output logic [DW/8-1:0]    m_sel_o,
  output logic [AW-1:0]      m_adr_o,
  output logic [DW-1:0]      m_dat_o,
  input  logic               m_ack_i,
  input  logic [DW-1:0]      m_dat_i,
  // rings
  input  logic [PW-1:0]      req_i,
  input  logic [PW-1:0]      rsp_i,
  output logic [PW-1:0]      req_o,
  output logic [PW-1:0]      rsp_o,
  output logic [15:0]        drop_cnt_o
);

  localparam int SW  = DW/8;
  localparam int QAW = $clog2(TXQ_DEPTH);
  localparam int TW  = $clog2(TIMEOUT+1);

  localparam logic [2:0]      c_typ_read  = 3'd1;
  localparam logic [2:0]      c_typ_write = 3'd2;
  localparam logic [2:0]      c_typ_ack   = 3'd3;
  localparam logic [ID_W-1:0] c_bcast     = '1;
  localparam logic [ID_W-1:0] c_server    = ID_W'(SERVER_ID);
  localparam logic [5:0]      c_max_age   = 6'(MAX_AGE);
  localparam logic [TW-1:0]   c_timeout   = TW'(TIMEOUT);
  localparam logic [QAW:0]    c_q_full    = (QAW+1)'(TXQ_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_RETRY = 2'd3;
  localparam logic [0:0] M_IDLE  = 1'b0;
  localparam logic [0:0] M_BUS   = 1'b1;

  typedef struct packed {
    logic [ID_W-1:0] sid;
    logic [ID_W-1:0] did;
    logic [5:0]      age;
    logic [2:0]      typ;
    logic [SW-1:0]   sel;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat;
  } pkt_t;

  function automatic logic f_empty(input pkt_t p);
    return (p.sid == '0) && (p.did == '0);
  endfunction

  function automatic pkt_t f_aged(input pkt_t p);
    pkt_t r;
    r     = p;
    r.age = p.age + 6'd1;
    return r;
  endfunction

  // registered state
  pkt_t             r_req_o, r_rsp_o, r_rsp;
  logic             r_rsp_vld;
  logic [15:0]      r_drop;
  pkt_t             r_q [TXQ_DEPTH];
  logic [QAW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [QAW:0]     r_count;
  logic [1:0]       r_s_state;
  logic [TW-1:0]    r_timer;
  logic [AW-1:0]    r_out_adr;
  logic             r_s_ack, r_s_rty;
  logic [DW-1:0]    r_s_dat;
  logic [0:0]       r_m_state;
  logic [ID_W-1:0]  r_m_sid;
  logic             r_m_we, r_m_read;
  logic [SW-1:0]    r_m_sel;
  logic [AW-1:0]    r_m_adr;
  logic [DW-1:0]    r_m_dat;

  // combinational
  pkt_t             w_req_in, w_rsp_in, w_req_nxt, w_rsp_nxt, w_push_pkt, w_rsp_new;
  logic             w_req_drop, w_rsp_drop, w_req_take, w_take_bcast;
  logic             w_pop, w_push, w_rsp_match, w_rsp_ins;
  logic             w_active, w_dec_rty;
  logic [ID_W-1:0]  w_did;
  logic [7:0]       w_top;
  logic [16:0]      w_drop_sum;
  logic [15:0]      w_drop_nxt;

  assign w_req_in = pkt_t'(req_i);
  assign w_rsp_in = pkt_t'(rsp_i);
  assign w_active = s_cyc_i && s_stb_i;

  // Request ring: age/drop, take requests for this node, then fill empty slot from queue
  always_comb begin
    w_req_nxt    = '0;
    w_req_drop   = 1'b0;
    w_req_take   = 1'b0;
    w_take_bcast = 1'b0;
    w_pop        = 1'b0;
    if (!f_empty(w_req_in)) begin
      if (w_req_in.age >= c_max_age) begin
        w_req_drop = 1'b1;
      end else if (w_req_in.did == c_bcast) begin
        // our own broadcast has been all the way round: retire it
        if (w_req_in.sid != id_i) begin
          w_req_nxt    = f_aged(w_req_in);
          w_req_take   = (r_m_state == M_IDLE);
          w_take_bcast = 1'b1;
        end
      end else if ((w_req_in.did == id_i) && (r_m_state == M_IDLE) && !r_rsp_vld) begin
        w_req_take = 1'b1;
      end else begin
        w_req_nxt = f_aged(w_req_in);
      end
    end
    if (f_empty(w_req_nxt) && (r_count != '0)) begin
      w_req_nxt     = r_q[r_rd_ptr];
      w_req_nxt.age = '0;
      w_pop         = 1'b1;
    end
  end

  // Response ring: age/drop, consume ACKs for this node, then insert pending response
  always_comb begin
    w_rsp_nxt   = '0;
    w_rsp_drop  = 1'b0;
    w_rsp_match = 1'b0;
    w_rsp_ins   = 1'b0;
    if (!f_empty(w_rsp_in)) begin
      if (w_rsp_in.age >= c_max_age) begin
        w_rsp_drop = 1'b1;
      end else if ((w_rsp_in.typ == c_typ_ack) && (w_rsp_in.did == id_i)) begin
        if ((r_s_state == S_WAIT) && (w_rsp_in.adr == r_out_adr)) begin
          w_rsp_match = 1'b1;
        end else if ((r_s_state == S_WAIT) || (r_s_state == S_DONE)) begin
          w_rsp_nxt = f_aged(w_rsp_in);
        end
        // stale ACKs while idle or retrying are discarded
      end else begin
        w_rsp_nxt = f_aged(w_rsp_in);
      end
    end
    if (f_empty(w_rsp_nxt) && r_rsp_vld) begin
      w_rsp_nxt = r_rsp;
      w_rsp_ins = 1'b1;
    end
  end

  // Slave address decode and TX queue push packet
  always_comb begin
    w_top     = s_adr_i[AW-1 -: 8];
    w_did     = c_server;
    w_dec_rty = 1'b0;
    if (w_top == 8'hC0) begin
      w_did = ID_W'(s_adr_i[AW-9 -: 4]);
    end else if (w_top == 8'hDF) begin
      if (s_we_i) w_did = c_bcast;
      else        w_dec_rty = 1'b1;
    end
    w_push = w_active && (r_s_state == S_IDLE) && !r_s_ack && !w_dec_rty &&
             (r_count != c_q_full);
    w_push_pkt     = '0;
    w_push_pkt.sid = id_i;
    w_push_pkt.did = w_did;
    w_push_pkt.typ = s_we_i ? c_typ_write : c_typ_read;
    w_push_pkt.sel = s_sel_i;
    w_push_pkt.adr = s_adr_i;
    w_push_pkt.dat = s_dat_i;
  end

  // Response packet built from a completed master read
  always_comb begin
    w_rsp_new     = '0;
    w_rsp_new.sid = id_i;
    w_rsp_new.did = r_m_sid;
    w_rsp_new.typ = c_typ_ack;
    w_rsp_new.sel = r_m_sel;
    w_rsp_new.adr = r_m_adr;
    w_rsp_new.dat = m_dat_i;
  end

  // Saturating drop counter; both rings may drop in the same cycle
  always_comb begin
    w_drop_sum = {1'b0, r_drop} + 17'(w_req_drop) + 17'(w_rsp_drop);
    w_drop_nxt = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  // Ring output registers and drop counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req_o <= '0;
      r_rsp_o <= '0;
      r_drop  <= '0;
    end else begin
      r_req_o <= w_req_nxt;
      r_rsp_o <= w_rsp_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  // TX queue storage (contents are don't-care while the queue is empty)
  always_ff @(posedge clk_i) begin
    if (w_push) r_q[r_wr_ptr] <= w_push_pkt;
  end

  // TX queue pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + QAW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + QAW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (QAW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (QAW+1)'(1);
    end
  end

  // Slave FSM: write acks, single outstanding read, timeout retry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s_state <= S_IDLE;
      r_timer   <= '0;
      r_out_adr <= '0;
      r_s_ack   <= 1'b0;
      r_s_rty   <= 1'b0;
      r_s_dat   <= '0;
    end else begin
      case (r_s_state)
        S_IDLE: begin
          if (r_s_ack && !s_stb_i) r_s_ack <= 1'b0;
          if (w_active && !r_s_ack && w_dec_rty) begin
            r_s_rty   <= 1'b1;
            r_s_state <= S_RETRY;
          end else if (w_push) begin
            r_timer <= '0;
            if (s_we_i) begin
              r_s_ack <= 1'b1;
            end else begin
              r_out_adr <= s_adr_i;
              r_s_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (w_rsp_match) begin
            r_s_dat   <= w_rsp_in.dat;
            r_s_ack   <= 1'b1;
            r_s_state <= S_DONE;
          end else if (r_timer == c_timeout) begin
            r_s_rty   <= 1'b1;
            r_s_state <= S_RETRY;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DONE: begin
          if (!w_active) begin
            r_s_ack   <= 1'b0;
            r_s_state <= S_IDLE;
          end
        end
        default: begin
          if (!w_active) begin
            r_s_rty   <= 1'b0;
            r_s_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Master FSM and response register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_m_state <= M_IDLE;
      r_m_sid   <= '0;
      r_m_we    <= 1'b0;
      r_m_read  <= 1'b0;
      r_m_sel   <= '0;
      r_m_adr   <= '0;
      r_m_dat   <= '0;
      r_rsp     <= '0;
      r_rsp_vld <= 1'b0;
    end else begin
      if (w_rsp_ins) r_rsp_vld <= 1'b0;
      if (r_m_state == M_IDLE) begin
        if (w_req_take) begin
          r_m_state <= M_BUS;
          r_m_sid   <= w_req_in.sid;
          r_m_we    <= w_take_bcast || (w_req_in.typ == c_typ_write);
          r_m_read  <= !w_take_bcast && (w_req_in.typ == c_typ_read);
          r_m_sel   <= w_req_in.sel;
          r_m_adr   <= w_req_in.adr;
          r_m_dat   <= w_req_in.dat;
        end
      end else if (m_ack_i) begin
        r_m_state <= M_IDLE;
        if (r_m_read) begin
          r_rsp     <= w_rsp_new;
          r_rsp_vld <= 1'b1;
        end
      end
    end
  end

  assign req_o      = r_req_o;
  assign rsp_o      = r_rsp_o;
  assign drop_cnt_o = r_drop;
  assign s_ack_o    = r_s_ack;
  assign s_rty_o    = r_s_rty;
  assign s_dat_o    = r_s_dat;
  assign m_cyc_o    = (r_m_state == M_BUS);
  assign m_stb_o    = (r_m_state == M_BUS);
  assign m_we_o     = (r_m_state == M_BUS) && r_m_we;
  assign m_sel_o    = r_m_read ? {SW{1'b1}} : r_m_sel;
  assign m_adr_o    = r_m_adr;
  assign m_dat_o    = r_m_dat;

endmodule
`default_nettype wire

// File: tb/tb_rf68000_ring_nic_q.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf68000_ring_nic_q
//  Purpose  : Directed self-checking bench for rf68000_ring_nic_q
//  Revision : 1.0  initial release
// ============================================================================
module tb_rf68000_ring_nic_q;

  localparam int ID_W    = 6;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SW      = DW/8;
  localparam int PW      = 2*ID_W + 6 + 3 + SW + AW + DW;
  localparam int TIMEOUT = 1023;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic [ID_W-1:0] id_i;
  logic            s_cyc_i, s_stb_i, s_we_i;
  logic [SW-1:0]   s_sel_i;
  logic [AW-1:0]   s_adr_i;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_o, s_rty_o;
  logic [DW-1:0]   s_dat_o;
  logic            m_cyc_o, m_stb_o, m_we_o;
  logic [SW-1:0]   m_sel_o;
  logic [AW-1:0]   m_adr_o;
  logic [DW-1:0]   m_dat_o;
  logic            m_ack_i;
  logic [DW-1:0]   m_dat_i;
  logic [PW-1:0]   req_i, rsp_i, req_o, rsp_o;
  logic [15:0]     drop_cnt_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [PW-1:0] exp_q [$];

  always #5 clk = ~clk;

  rf68000_ring_nic_q dut (
    .clk_i(clk), .rst_ni(rst_ni), .id_i(id_i),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_sel_i(s_sel_i),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_ack_o(s_ack_o), .s_rty_o(s_rty_o),
    .s_dat_o(s_dat_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i),
    .req_i(req_i), .rsp_i(rsp_i), .req_o(req_o), .rsp_o(rsp_o),
    .drop_cnt_o(drop_cnt_o)
  );

  function automatic logic [PW-1:0] mk(input logic [5:0] sid, input logic [5:0] did,
                                       input logic [5:0] age, input logic [2:0] typ,
                                       input logic [3:0] sel, input logic [31:0] adr,
                                       input logic [31:0] dat);
    return {sid, did, age, typ, sel, adr, dat};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // wait (bounded) for our next packet on req_o and compare with scoreboard head
  task automatic expect_req(input string tag, input int budget);
    int n;
    n = 0;
    while ((req_o[PW-1 -: 2*ID_W] == '0) && (n < budget)) begin
      step();
      n++;
    end
    chk({tag, "_seen"}, 128'(req_o[PW-1 -: 2*ID_W] != '0), 1);
    if (exp_q.size() > 0) chk(tag, req_o, exp_q.pop_front());
  endtask

  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we;
    s_sel_i = 4'hF; s_adr_i = adr;  s_dat_i = dat;
  endtask

  task automatic bus_idle();
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic got;
    id_i = 6'd3; s_sel_i = '0; s_adr_i = '0; s_dat_i = '0;
    bus_idle();
    m_ack_i = 1'b0; m_dat_i = '0; req_i = '0; rsp_i = '0;

    // ---- reset state
    rst_ni = 1'b0;
    repeat (3) step();
    chk("rst_req_o", req_o, 0);
    chk("rst_rsp_o", rsp_o, 0);
    chk("rst_s_ack", s_ack_o, 0);
    chk("rst_s_rty", s_rty_o, 0);
    chk("rst_m_cyc", m_cyc_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    rst_ni = 1'b1;
    step();

    // ---- local write to node 5, acked next cycle, inserted with age 0
    bus(1'b1, 32'hC050_0010, 32'h0000_1234);
    exp_q.push_back(mk(6'd3, 6'd5, 6'd0, 3'd2, 4'hF, 32'hC050_0010, 32'h0000_1234));
    step();
    chk("wr_ack", s_ack_o, 1);
    expect_req("wr_pkt", 8);
    bus_idle();
    step();
    chk("wr_ack_drop", s_ack_o, 0);

    // ---- node 5 executes the write
    id_i  = 6'd5;
    req_i = mk(6'd3, 6'd5, 6'd2, 3'd2, 4'hF, 32'hC050_0010, 32'h0000_1234);
    step();
    req_i = '0;
    chk("tgt_removed", req_o, 0);
    chk("tgt_cyc", m_cyc_o, 1);
    chk("tgt_stb", m_stb_o, 1);
    chk("tgt_we", m_we_o, 1);
    chk("tgt_adr", m_adr_o, 32'hC050_0010);
    chk("tgt_dat", m_dat_o, 32'h0000_1234);
    m_ack_i = 1'b1;
    step();
    m_ack_i = 1'b0;
    chk("tgt_idle", m_cyc_o, 0);
    step();
    chk("tgt_no_rsp", rsp_o, 0);

    // ---- node 5 executes a read; a second request while busy recirculates
    req_i = mk(6'd62, 6'd5, 6'd1, 3'd1, 4'h3, 32'h0000_1000, 32'h0);
    step();
    chk("mrd_cyc", m_cyc_o, 1);
    chk("mrd_we", m_we_o, 0);
    chk("mrd_sel", m_sel_o, 4'hF);
    req_i = mk(6'd9, 6'd5, 6'd4, 3'd2, 4'h1, 32'h0000_2000, 32'h77);
    step();
    req_i = '0;
    chk("recirc", req_o, mk(6'd9, 6'd5, 6'd5, 3'd2, 4'h1, 32'h0000_2000, 32'h77));
    m_ack_i = 1'b1; m_dat_i = 32'hCAFE_F00D;
    step();
    m_ack_i = 1'b0;
    step();
    chk("mrd_rsp", rsp_o, mk(6'd5, 6'd62, 6'd0, 3'd3, 4'h3, 32'h0000_1000, 32'hCAFE_F00D));

    // ---- node 3 reads from the server, matching ACK completes it
    id_i = 6'd3;
    bus(1'b0, 32'h4000_0000, 32'h0);
    exp_q.push_back(mk(6'd3, 6'd62, 6'd0, 3'd1, 4'hF, 32'h4000_0000, 32'h0));
    step();
    chk("rd_no_ack", s_ack_o, 0);
    expect_req("rd_pkt", 8);
    rsp_i = mk(6'd62, 6'd3, 6'd5, 3'd3, 4'hF, 32'h4000_0000, 32'hDEAD_BEEF);
    step();
    rsp_i = '0;
    chk("rd_rsp_removed", rsp_o, 0);
    chk("rd_ack", s_ack_o, 1);
    chk("rd_dat", s_dat_o, 32'hDEAD_BEEF);
    bus_idle();
    step();
    chk("rd_ack_drop", s_ack_o, 0);

    // ---- stale ACK for us is discarded; ACK for another node is forwarded
    rsp_i = mk(6'd62, 6'd3, 6'd2, 3'd3, 4'hF, 32'h0000_1234, 32'h1);
    step();
    chk("stale_ack", rsp_o, 0);
    rsp_i = mk(6'd62, 6'd9, 6'd2, 3'd3, 4'hF, 32'h0000_1234, 32'h1);
    step();
    rsp_i = '0;
    chk("fwd_ack", rsp_o, mk(6'd62, 6'd9, 6'd3, 3'd3, 4'hF, 32'h0000_1234, 32'h1));

    // ---- read of broadcast space is refused with retry
    bus(1'b0, 32'hDF00_0000, 32'h0);
    step();
    chk("df_rty", s_rty_o, 1);
    step();
    chk("df_no_pkt", req_o, 0);
    bus_idle();
    step();
    chk("df_rty_drop", s_rty_o, 0);

    // ---- broadcast from elsewhere: executed and forwarded; own broadcast retired
    req_i = mk(6'd7, 6'd63, 6'd1, 3'd2, 4'hF, 32'hDF00_0004, 32'h55);
    step();
    req_i = '0;
    chk("bc_fwd", req_o, mk(6'd7, 6'd63, 6'd2, 3'd2, 4'hF, 32'hDF00_0004, 32'h55));
    chk("bc_cyc", m_cyc_o, 1);
    chk("bc_adr", m_adr_o, 32'hDF00_0004);
    m_ack_i = 1'b1;
    step();
    m_ack_i = 1'b0;
    req_i = mk(6'd3, 6'd63, 6'd4, 3'd2, 4'hF, 32'hDF00_0004, 32'h55);
    step();
    req_i = '0;
    chk("bc_own_removed", req_o, 0);
    chk("bc_own_no_exec", m_cyc_o, 0);

    // ---- read timeout: retry exactly TIMEOUT+1 clocks after push
    bus(1'b0, 32'h4000_0100, 32'h0);
    exp_q.push_back(mk(6'd3, 6'd62, 6'd0, 3'd1, 4'hF, 32'h4000_0100, 32'h0));
    step();
    n = 0;
    while (!s_rty_o && (n < 2000)) begin
      step();
      n++;
      if ((req_o[PW-1 -: 2*ID_W] != '0) && (exp_q.size() > 0))
        chk("to_pkt", req_o, exp_q.pop_front());
    end
    chk("to_cycles", n, TIMEOUT + 1);
    chk("to_pkt_seen", exp_q.size(), 0);
    bus_idle();
    step();
    chk("to_rty_drop", s_rty_o, 0);

    // ---- fill the TX queue while the ring is fully occupied
    req_i = mk(6'd10, 6'd20, 6'd1, 3'd2, 4'h1, 32'h0000_AAAA, 32'h0000_BBBB);
    for (int k = 0; k < 4; k++) begin
      bus(1'b1, 32'hC070_0000 + 32'(k*4), 32'(k));
      exp_q.push_back(mk(6'd3, 6'd7, 6'd0, 3'd2, 4'hF, 32'hC070_0000 + 32'(k*4), 32'(k)));
      step();
      chk("fill_ack", s_ack_o, 1);
      bus_idle();
      step();
    end
    bus(1'b1, 32'hC070_0010, 32'h4);
    exp_q.push_back(mk(6'd3, 6'd7, 6'd0, 3'd2, 4'hF, 32'hC070_0010, 32'h4));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("full_stall", s_ack_o, 0);
    end
    chk("full_fwd", req_o, mk(6'd10, 6'd20, 6'd2, 3'd2, 4'h1, 32'h0000_AAAA, 32'h0000_BBBB));
    req_i = '0;
    got = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (req_o[PW-1 -: 2*ID_W] != '0) begin
        if (exp_q.size() > 0) chk("drain", req_o, exp_q.pop_front());
        else                  chk("drain_extra", req_o, 0);
      end
      if (s_ack_o && s_stb_i) begin
        got = 1'b1;
        bus_idle();
      end
    end
    chk("stall_acked", got, 1);
    chk("drain_done", exp_q.size(), 0);

    // ---- aging: age 63 dropped and counted, age 62 still forwarded
    req_i = mk(6'd10, 6'd20, 6'd63, 3'd2, 4'h1, 32'h0000_0100, 32'h1);
    step();
    req_i = '0;
    chk("age_drop_slot", req_o, 0);
    chk("age_drop_cnt", drop_cnt_o, 1);
    req_i = mk(6'd10, 6'd20, 6'd62, 3'd2, 4'h1, 32'h0000_0100, 32'h1);
    step();
    req_i = '0;
    chk("age62_fwd", req_o, mk(6'd10, 6'd20, 6'd63, 3'd2, 4'h1, 32'h0000_0100, 32'h1));
    chk("age62_cnt", drop_cnt_o, 1);
    rsp_i = mk(6'd10, 6'd20, 6'd63, 3'd3, 4'h1, 32'h0000_0100, 32'h1);
    step();
    rsp_i = '0;
    chk("rsp_age_drop", rsp_o, 0);
    chk("rsp_age_cnt", drop_cnt_o, 2);

    // ---- asynchronous reset during a master bus cycle
    req_i = mk(6'd62, 6'd3, 6'd0, 3'd2, 4'hF, 32'h0000_3000, 32'h99);
    step();
    req_i = '0;
    chk("bus_before_rst", m_cyc_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_cyc", m_cyc_o, 0);
    chk("rst_mid_drop", drop_cnt_o, 0);
    step();
    rst_ni = 1'b1;
    step();
    chk("post_rst_cyc", m_cyc_o, 0);
    chk("post_rst_ack", s_ack_o, 0);
    chk("post_rst_req", req_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
